// File: rtl/cvxif_offload_unit.sv
// Core-side CORE-V-X-IF initiator: issues offloaded instructions and tracks outstanding ones.
// Completes them to writeback, turning rejects into illegal-instruction exceptions.
module cvxif_offload_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TRANS_ID_BITS  = 4,
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned IllegalCause   = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    input  logic [31:0]                   instr_i,
    input  logic [XLEN-1:0]               rs1_i,
    input  logic [XLEN-1:0]               rs2_i,
    input  logic [TRANS_ID_BITS-1:0]      trans_id_i,
    // req  {x_issue_valid, instr, rs[0], rs[1], id, x_result_ready}
    output logic [2*XLEN+X_ID_WIDTH+33:0] cvxif_req_o,
    // resp {x_issue_ready, accept, x_result_valid, result.id, result.data, result.we}
    input  logic [XLEN+X_ID_WIDTH+3:0]    cvxif_resp_i,
    output logic                          wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]      wb_trans_id_o,
    output logic [XLEN-1:0]               wb_data_o,
    output logic                          wb_we_o,
    output logic                          wb_ex_valid_o,
    output logic [XLEN-1:0]               wb_ex_cause_o,
    output logic [XLEN-1:0]               wb_ex_tval_o
);

    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned IW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    logic                     x_issue_ready, x_accept, x_result_valid, x_result_we;
    logic [X_ID_WIDTH-1:0]    x_result_id;
    logic [XLEN-1:0]          x_result_data;

    assign {x_issue_ready, x_accept, x_result_valid, x_result_id, x_result_data, x_result_we} = cvxif_resp_i;

    state_e                   state_q;
    logic [31:0]              iss_instr_q;
    logic [XLEN-1:0]          iss_rs1_q, iss_rs2_q;
    logic [X_ID_WIDTH-1:0]    iss_id_q;
    logic [TRANS_ID_BITS-1:0] iss_tid_q;
    logic                     iss_killed_q;

    logic [MaxOutstanding-1:0] tbl_valid_q, tbl_killed_q;
    logic [X_ID_WIDTH-1:0]     tbl_id_q  [MaxOutstanding];
    logic [TRANS_ID_BITS-1:0]  tbl_tid_q [MaxOutstanding];
    logic [CW-1:0]             count_q;

    logic                      rej_valid_q;
    logic [TRANS_ID_BITS-1:0]  rej_tid_q;
    logic [31:0]               rej_instr_q;

    logic          issue_hs, alloc, free_found, hit;
    logic [IW-1:0] free_idx, hit_idx;

    assign instr_ready_o = (state_q == IDLE) && (count_q < CW'(MaxOutstanding)) && !rej_valid_q;
    assign issue_hs      = (state_q == ISSUE) && x_issue_ready;
    assign alloc         = issue_hs && x_accept;
    assign cvxif_req_o   = {state_q == ISSUE, iss_instr_q, iss_rs1_q, iss_rs2_q, iss_id_q, 1'b1};

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            if (!tbl_valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            if (x_result_valid && tbl_valid_q[i] && (tbl_id_q[i] == x_result_id) && !hit) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    // A flush cannot retract an issue already on the bus; it only tags it killed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            iss_instr_q  <= '0;
            iss_rs1_q    <= '0;
            iss_rs2_q    <= '0;
            iss_id_q     <= '0;
            iss_tid_q    <= '0;
            iss_killed_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (instr_valid_i && instr_ready_o && !flush_i) begin
                        state_q      <= ISSUE;
                        iss_instr_q  <= instr_i;
                        iss_rs1_q    <= rs1_i;
                        iss_rs2_q    <= rs2_i;
                        iss_id_q     <= trans_id_i[X_ID_WIDTH-1:0];
                        iss_tid_q    <= trans_id_i;
                        iss_killed_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (flush_i) iss_killed_q <= 1'b1;
                    if (x_issue_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_valid_q  <= '0;
            tbl_killed_q <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < MaxOutstanding; i++) begin
                tbl_id_q[i]  <= '0;
                tbl_tid_q[i] <= '0;
            end
        end else begin
            if (flush_i) tbl_killed_q <= tbl_killed_q | tbl_valid_q;
            if (hit) tbl_valid_q[hit_idx] <= 1'b0;
            if (alloc) begin
                tbl_valid_q[free_idx]  <= 1'b1;
                tbl_killed_q[free_idx] <= iss_killed_q | flush_i;
                tbl_id_q[free_idx]     <= iss_id_q;
                tbl_tid_q[free_idx]    <= iss_tid_q;
            end
            if (alloc && !hit)      count_q <= count_q + 1'b1;
            else if (!alloc && hit) count_q <= count_q - 1'b1;
        end
    end

    // Coprocessor results take the writeback slot ahead of a pending reject.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rej_valid_q   <= 1'b0;
            rej_tid_q     <= '0;
            rej_instr_q   <= '0;
            wb_valid_o    <= 1'b0;
            wb_trans_id_o <= '0;
            wb_data_o     <= '0;
            wb_we_o       <= 1'b0;
            wb_ex_valid_o <= 1'b0;
            wb_ex_cause_o <= '0;
            wb_ex_tval_o  <= '0;
        end else begin
            wb_valid_o    <= 1'b0;
            wb_trans_id_o <= '0;
            wb_data_o     <= '0;
            wb_we_o       <= 1'b0;
            wb_ex_valid_o <= 1'b0;
            wb_ex_cause_o <= '0;
            wb_ex_tval_o  <= '0;

            if (flush_i) begin
                rej_valid_q <= 1'b0;
            end else if (issue_hs && !x_accept && !iss_killed_q) begin
                rej_valid_q <= 1'b1;
                rej_tid_q   <= iss_tid_q;
                rej_instr_q <= iss_instr_q;
            end else if (rej_valid_q && !x_result_valid) begin
                rej_valid_q <= 1'b0;
            end

            if (hit && !tbl_killed_q[hit_idx] && !flush_i) begin
                wb_valid_o    <= 1'b1;
                wb_trans_id_o <= tbl_tid_q[hit_idx];
                wb_data_o     <= x_result_data;
                wb_we_o       <= x_result_we;
            end else if (rej_valid_q && !x_result_valid && !flush_i) begin
                wb_valid_o    <= 1'b1;
                wb_trans_id_o <= rej_tid_q;
                wb_ex_valid_o <= 1'b1;
                wb_ex_cause_o <= XLEN'(IllegalCause);
                wb_ex_tval_o  <= XLEN'(rej_instr_q);
            end
        end
    end

    a_result_matches: assert property (@(posedge clk_i) disable iff (!rst_ni)
        x_result_valid |-> hit);
    a_alloc_has_slot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        alloc |-> free_found);
    a_count_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (alloc && !hit) |-> (count_q < CW'(MaxOutstanding)));
    a_count_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (hit && !alloc) |-> (count_q != '0));

endmodule

// File: tb/tb_cvxif_offload_unit.sv
// Directed bench for cvxif_offload_unit: accept, reject, backpressure, full, collision, flush, reset.
module tb_cvxif_offload_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni, flush_i, instr_valid_i, instr_ready_o;
    logic [31:0] instr_i, rs1_i, rs2_i;
    logic [3:0]  trans_id_i;
    logic [101:0] cvxif_req_o;
    logic [39:0]  cvxif_resp_i;
    logic        wb_valid_o, wb_we_o, wb_ex_valid_o;
    logic [3:0]  wb_trans_id_o;
    logic [31:0] wb_data_o, wb_ex_cause_o, wb_ex_tval_o;

    logic        x_issue_ready, x_accept, x_res_valid, x_res_we;
    logic [3:0]  x_res_id;
    logic [31:0] x_res_data;

    logic        req_valid, req_rready;
    logic [31:0] req_instr, req_rs1, req_rs2;
    logic [3:0]  req_id;

    logic [100:0] req_vec;
    logic [38:0]  wb_vec;
    logic [38:0]  e;
    logic [100:0] er;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    assign cvxif_resp_i = {x_issue_ready, x_accept, x_res_valid, x_res_id, x_res_data, x_res_we};
    assign {req_valid, req_instr, req_rs1, req_rs2, req_id, req_rready} = cvxif_req_o;
    assign req_vec = {req_valid, req_instr, req_rs1, req_rs2, req_id};
    assign wb_vec  = {wb_valid_o, wb_we_o, wb_ex_valid_o, wb_trans_id_o, wb_data_o};

    cvxif_offload_unit #(
        .XLEN(32), .TRANS_ID_BITS(4), .X_ID_WIDTH(4), .MaxOutstanding(4), .IllegalCause(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .trans_id_i(trans_id_i),
        .cvxif_req_o(cvxif_req_o), .cvxif_resp_i(cvxif_resp_i),
        .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o), .wb_data_o(wb_data_o),
        .wb_we_o(wb_we_o), .wb_ex_valid_o(wb_ex_valid_o),
        .wb_ex_cause_o(wb_ex_cause_o), .wb_ex_tval_o(wb_ex_tval_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_instr(input logic [3:0] tid, input logic [31:0] ins,
                              input logic [31:0] a, input logic [31:0] b);
        instr_valid_i = 1'b1; trans_id_i = tid; instr_i = ins; rs1_i = a; rs2_i = b;
        tick();
        instr_valid_i = 1'b0;
    endtask

    task automatic coproc_issue(input logic acc);
        x_issue_ready = 1'b1; x_accept = acc;
        tick();
        x_issue_ready = 1'b0; x_accept = 1'b0;
    endtask

    task automatic coproc_result(input logic [3:0] id, input logic [31:0] d, input logic we);
        x_res_valid = 1'b1; x_res_id = id; x_res_data = d; x_res_we = we;
        tick();
        x_res_valid = 1'b0; x_res_id = '0; x_res_data = '0; x_res_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; flush_i = 0; instr_valid_i = 0; instr_i = '0; rs1_i = '0; rs2_i = '0;
        trans_id_i = '0; x_issue_ready = 0; x_accept = 0; x_res_valid = 0; x_res_id = '0;
        x_res_data = '0; x_res_we = 0;
        tick(); tick();
        n_tests++;
        if ({req_valid, req_rready, wb_vec, wb_ex_cause_o, wb_ex_tval_o} !== {1'b0, 1'b1, 39'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b rr=%b wb=%h got exp v=0 rr=1 wb=0", req_valid, req_rready, wb_vec);
        end
        rst_ni = 1'b1;
        tick();
        n_tests++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %b exp 1", instr_ready_o);
        end
    endtask

    task automatic test_accept();
        send_instr(4'd3, 32'h0000_000B, 32'd5, 32'd7);
        er = {1'b1, 32'h0000_000B, 32'd5, 32'd7, 4'd3};
        n_tests++;
        if (req_vec !== er || instr_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL accept_issue: got %h rdy=%b exp %h rdy=0", req_vec, instr_ready_o, er);
        end
        coproc_issue(1'b1);
        n_tests++;
        if (req_valid !== 1'b0 || instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL accept_idle: got v=%b rdy=%b exp v=0 rdy=1", req_valid, instr_ready_o);
        end
        coproc_result(4'd3, 32'd12, 1'b1);
        e = {1'b1, 1'b1, 1'b0, 4'd3, 32'd12};
        n_tests++;
        if (wb_vec !== e) begin
            n_fail++; $display("FAIL accept_wb: got %h exp %h", wb_vec, e);
        end
        tick();
        n_tests++;
        if (wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL accept_wb_single: got %b exp 0", wb_valid_o);
        end
    endtask

    task automatic test_reject();
        send_instr(4'd6, 32'h0000_702B, 32'd1, 32'd2);
        coproc_issue(1'b0);
        n_tests++;
        if (instr_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reject_pending: got rdy=%b wb=%b exp rdy=0 wb=0", instr_ready_o, wb_valid_o);
        end
        tick();
        e = {1'b1, 1'b0, 1'b1, 4'd6, 32'd0};
        n_tests++;
        if (wb_vec !== e || wb_ex_cause_o !== 32'd2 || wb_ex_tval_o !== 32'h0000_702B) begin
            n_fail++;
            $display("FAIL reject_wb: got %h cause=%h tval=%h exp %h cause=2 tval=702b", wb_vec, wb_ex_cause_o, wb_ex_tval_o, e);
        end
        n_tests++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reject_ready: got %b exp 1", instr_ready_o);
        end
    endtask

    task automatic test_backpressure();
        send_instr(4'd1, 32'h1234_560B, 32'hAAAA_0001, 32'hBBBB_0002);
        er = {1'b1, 32'h1234_560B, 32'hAAAA_0001, 32'hBBBB_0002, 4'd1};
        instr_valid_i = 1'b1; instr_i = 32'hDEAD_BEEF; rs1_i = 32'h3; rs2_i = 32'h4; trans_id_i = 4'd9;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (req_vec !== er || instr_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL backpressure_c%0d: got %h rdy=%b exp %h rdy=0", c, req_vec, instr_ready_o, er);
            end
        end
        instr_valid_i = 1'b0;
        coproc_issue(1'b1);
        coproc_result(4'd1, 32'h0000_0BAD, 1'b1);
        e = {1'b1, 1'b1, 1'b0, 4'd1, 32'h0000_0BAD};
        n_tests++;
        if (wb_vec !== e) begin
            n_fail++; $display("FAIL backpressure_wb: got %h exp %h", wb_vec, e);
        end
    endtask

    task automatic test_full();
        for (int t = 8; t < 12; t++) begin
            send_instr(4'(t), 32'h0000_000B, 32'(t), 32'd0);
            coproc_issue(1'b1);
        end
        n_tests++;
        if (instr_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready: got %b exp 0", instr_ready_o);
        end
        coproc_result(4'd8, 32'h108, 1'b1);
        e = {1'b1, 1'b1, 1'b0, 4'd8, 32'h108};
        n_tests++;
        if (wb_vec !== e || instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_oldest: got %h rdy=%b exp %h rdy=1", wb_vec, instr_ready_o, e);
        end
        // simultaneous allocate (tid 12) and free (tid 9)
        send_instr(4'd12, 32'h0000_000B, 32'd0, 32'd0);
        x_issue_ready = 1'b1; x_accept = 1'b1;
        x_res_valid = 1'b1; x_res_id = 4'd9; x_res_data = 32'h109; x_res_we = 1'b1;
        tick();
        x_issue_ready = 1'b0; x_accept = 1'b0; x_res_valid = 1'b0;
        e = {1'b1, 1'b1, 1'b0, 4'd9, 32'h109};
        n_tests++;
        if (wb_vec !== e || instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_collide_alloc: got %h rdy=%b exp %h rdy=1", wb_vec, instr_ready_o, e);
        end
        send_instr(4'd13, 32'h0000_000B, 32'd0, 32'd0);
        coproc_issue(1'b1);
        n_tests++;
        if (instr_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_count: got %b exp 0", instr_ready_o);
        end
        for (int t = 10; t < 14; t++) begin
            coproc_result(4'(t), 32'(t + 256), 1'b1);
            e = {1'b1, 1'b1, 1'b0, 4'(t), 32'(t + 256)};
            n_tests++;
            if (wb_vec !== e) begin
                n_fail++; $display("FAIL full_drain_%0d: got %h exp %h", t, wb_vec, e);
            end
        end
    endtask

    task automatic test_collision();
        send_instr(4'd4, 32'h0000_000B, 32'd0, 32'd0);
        coproc_issue(1'b1);
        send_instr(4'd5, 32'h0000_502B, 32'd0, 32'd0);
        coproc_issue(1'b0);
        coproc_result(4'd4, 32'h55, 1'b1);
        e = {1'b1, 1'b1, 1'b0, 4'd4, 32'h55};
        n_tests++;
        if (wb_vec !== e) begin
            n_fail++; $display("FAIL collision_result_first: got %h exp %h", wb_vec, e);
        end
        tick();
        e = {1'b1, 1'b0, 1'b1, 4'd5, 32'd0};
        n_tests++;
        if (wb_vec !== e || wb_ex_tval_o !== 32'h0000_502B) begin
            n_fail++; $display("FAIL collision_exc_next: got %h tval=%h exp %h tval=502b", wb_vec, wb_ex_tval_o, e);
        end
    endtask

    task automatic test_flush();
        send_instr(4'd1, 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        send_instr(4'd2, 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        coproc_result(4'd1, 32'h11, 1'b1);
        n_tests++;
        if (wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL flush_killed1: got %h exp 0", wb_vec);
        end
        coproc_result(4'd2, 32'h22, 1'b1);
        n_tests++;
        if (wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL flush_killed2: got %h exp 0", wb_vec);
        end
        // flush while an issue is on the bus; it still completes but silently
        send_instr(4'd3, 32'h0000_000B, 32'd0, 32'd0);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_tests++;
        if (req_valid !== 1'b1) begin
            n_fail++; $display("FAIL flush_issue_held: got %b exp 1", req_valid);
        end
        coproc_issue(1'b1);
        coproc_result(4'd3, 32'h33, 1'b1);
        n_tests++;
        if (wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL flush_issue_killed: got %h exp 0", wb_vec);
        end
        send_instr(4'd4, 32'h0000_402B, 32'd0, 32'd0);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        coproc_issue(1'b0);
        n_tests++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_reject_dropped: got rdy=%b exp 1", instr_ready_o);
        end
        tick();
        n_tests++;
        if (wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL flush_reject_nowb: got %h exp 0", wb_vec);
        end
        send_instr(4'd5, 32'h0000_502B, 32'd0, 32'd0); coproc_issue(1'b0);
        flush_i = 1'b1; tick(); flush_i = 1'b0;
        n_tests++;
        if (wb_vec !== 39'd0 || instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_pending_reject: got %h rdy=%b exp 0 rdy=1", wb_vec, instr_ready_o);
        end
        instr_valid_i = 1'b1; trans_id_i = 4'd6; flush_i = 1'b1;
        tick();
        instr_valid_i = 1'b0; flush_i = 1'b0;
        n_tests++;
        if (req_valid !== 1'b0 || instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_handshake: got v=%b rdy=%b exp v=0 rdy=1", req_valid, instr_ready_o);
        end
        send_instr(4'd9, 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        flush_i = 1'b1; coproc_result(4'd9, 32'h99, 1'b1); flush_i = 1'b0;
        n_tests++;
        if (wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL flush_same_result: got %h exp 0", wb_vec);
        end
        send_instr(4'd7, 32'h0000_000B, 32'd1, 32'd2); coproc_issue(1'b1);
        coproc_result(4'd7, 32'h0000_ABCD, 1'b0);
        e = {1'b1, 1'b0, 1'b0, 4'd7, 32'h0000_ABCD};
        n_tests++;
        if (wb_vec !== e) begin
            n_fail++; $display("FAIL flush_recover: got %h exp %h", wb_vec, e);
        end
    endtask

    task automatic test_reset_midop();
        send_instr(4'd2, 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        send_instr(4'd3, 32'h0000_000B, 32'd0, 32'd0);
        rst_ni = 1'b0;
        #2;
        n_tests++;
        if (req_valid !== 1'b0 || instr_ready_o !== 1'b1 || wb_vec !== 39'd0) begin
            n_fail++; $display("FAIL midreset_async: got v=%b rdy=%b wb=%h exp 0 1 0", req_valid, instr_ready_o, wb_vec);
        end
        tick(); rst_ni = 1'b1; tick();
        for (int t = 1; t < 4; t++) begin
            send_instr(4'(t), 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        end
        n_tests++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_count3: got %b exp 1", instr_ready_o);
        end
        send_instr(4'd4, 32'h0000_000B, 32'd0, 32'd0); coproc_issue(1'b1);
        n_tests++;
        if (instr_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL midreset_count4: got %b exp 0", instr_ready_o);
        end
        for (int t = 1; t < 5; t++) coproc_result(4'(t), 32'd0, 1'b0);
        tick();
        n_tests++;
        if (instr_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL midreset_drained: got %b exp 1", instr_ready_o);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_accept();
        test_reject();
        test_backpressure();
        test_full();
        test_collision();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
